tanh_grad_stream: RTL and testbench

- Backward-direction companion to the forward tanh activation in the GRU datapath.
- Consumes a stream of (tanh output y, upstream gradient g) pairs in signed Q4.4 format, where 16 represents 1.0.
- Produces the input gradient dx = g * (1 - y*y).
- 3-stage pipeline with valid/ready handshakes on both sides; flags the last element of each gate vector for the GRU backprop sequencer.

---
 rtl/tanh_grad_stream.sv | 137 +++++++++++++
 tb/tb_tanh_grad_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_grad_stream.sv
// Backward pass of the GRU tanh activation: dx = g * (1 - y*y) in signed Q4.4,
// three-stage valid/ready pipeline with per-vector last flag and a sticky clamp flag.
module tanh_grad_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_y,
    input  logic signed [DATA_WIDTH-1:0] in_g,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         clamp_seen,
    input  logic                         clear
);

    localparam int SQ_W = 2 * DATA_WIDTH;
    localparam int P_W  = 2 * DATA_WIDTH + 2;

    localparam logic signed [DATA_WIDTH-1:0] Y_MAX   = DATA_WIDTH'(16);
    localparam logic signed [DATA_WIDTH-1:0] Y_MIN   = DATA_WIDTH'(-16);
    localparam logic signed [DATA_WIDTH:0]   OM_ONE  = (DATA_WIDTH + 1)'(16);
    localparam logic signed [P_W-1:0]        OUT_MAX = P_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [P_W-1:0]        OUT_MIN = P_W'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic [CNT_WIDTH-1:0]         LAST_IDX = CNT_WIDTH'(VEC_LEN - 1);

    function automatic logic signed [DATA_WIDTH-1:0] clamp_unit(
        input logic signed [DATA_WIDTH-1:0] y
    );
        logic signed [DATA_WIDTH-1:0] r;
        r = y;
        if (y > Y_MAX) r = Y_MAX;
        else if (y < Y_MIN) r = Y_MIN;
        return r;
    endfunction

    // Arithmetic shift floors toward -inf before saturating to the output range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_shift4(
        input logic signed [P_W-1:0] p
    );
        logic signed [P_W-1:0] sh;
        sh = p >>> 4;
        if (sh > OUT_MAX) sh = OUT_MAX;
        else if (sh < OUT_MIN) sh = OUT_MIN;
        return DATA_WIDTH'(sh);
    endfunction

    logic                         advance, in_xfer, out_xfer;
    logic signed [DATA_WIDTH-1:0] y_clamped;
    logic signed [SQ_W-1:0]       y_sq;
    logic signed [P_W-1:0]        prod;

    logic                         vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic signed [DATA_WIDTH-1:0] sq_p1_q, sq_p1_d, g_p1_q, g_p1_d;
    logic signed [DATA_WIDTH:0]   om_p2_q, om_p2_d;
    logic signed [DATA_WIDTH-1:0] g_p2_q, g_p2_d;
    logic signed [DATA_WIDTH-1:0] out_p3_q, out_p3_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
    logic                         clamp_seen_q, clamp_seen_d;

    always_comb begin
        advance   = !vld_p3_q || out_ready;
        in_xfer   = in_valid && advance;
        out_xfer  = vld_p3_q && out_ready;
        y_clamped = clamp_unit(in_y);
        y_sq      = SQ_W'(y_clamped) * SQ_W'(y_clamped);
        prod      = P_W'(g_p2_q) * P_W'(om_p2_q);

        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        vld_p3_d = vld_p3_q;
        sq_p1_d  = sq_p1_q;
        g_p1_d   = g_p1_q;
        om_p2_d  = om_p2_q;
        g_p2_d   = g_p2_q;
        out_p3_d = out_p3_q;

        // All stages move in lockstep; bubbles travel as vld=0.
        if (advance) begin
            vld_p1_d = in_valid;
            sq_p1_d  = DATA_WIDTH'(y_sq >>> 4);
            g_p1_d   = in_g;
            vld_p2_d = vld_p1_q;
            om_p2_d  = OM_ONE - $signed({sq_p1_q[DATA_WIDTH-1], sq_p1_q});
            g_p2_d   = g_p1_q;
            vld_p3_d = vld_p2_q;
            if (vld_p2_q) out_p3_d = sat_shift4(prod);
        end

        clamp_seen_d = clamp_seen_q;
        if (clear) clamp_seen_d = 1'b0;
        else if (in_xfer && (y_clamped != in_y)) clamp_seen_d = 1'b1;

        cnt_d = cnt_q;
        if (clear) cnt_d = '0;
        else if (out_xfer) cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end

    // ---- stage 1 / 2 datapath registers (no reset) ----
    always_ff @(posedge clk) begin
        sq_p1_q <= sq_p1_d;
        g_p1_q  <= g_p1_d;
        om_p2_q <= om_p2_d;
        g_p2_q  <= g_p2_d;
    end

    // ---- control and stage 3 output registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            vld_p3_q     <= 1'b0;
            out_p3_q     <= '0;
            cnt_q        <= '0;
            clamp_seen_q <= 1'b0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            vld_p3_q     <= vld_p3_d;
            out_p3_q     <= out_p3_d;
            cnt_q        <= cnt_d;
            clamp_seen_q <= clamp_seen_d;
        end
    end

    assign in_ready   = advance;
    assign out        = out_p3_q;
    assign out_valid  = vld_p3_q;
    assign out_last   = vld_p3_q && (cnt_q == LAST_IDX);
    assign clamp_seen = clamp_seen_q;

endmodule

// File: tb/tb_tanh_grad_stream.sv
// Scoreboard bench for tanh_grad_stream: expected dx values are queued on every
// input transfer and popped by a monitor on every output transfer.
module tb_tanh_grad_stream;

    localparam int DW = 8;
    localparam int VL = 4;
    localparam int CW = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] in_y, in_g, out;
    logic                 in_valid, in_ready, out_valid, out_ready, out_last;
    logic                 clamp_seen, clear;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int m_pos   = 0;
    bit m_clamp = 1'b0;
    bit rand_rdy = 1'b0;
    bit bp_done  = 1'b0;

    tanh_grad_stream #(.DATA_WIDTH(DW), .VEC_LEN(VL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_y(in_y), .in_g(in_g), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .clamp_seen(clamp_seen), .clear(clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: clamp y, square, floor-divide by 16, scale g, floor-divide, saturate.
    function automatic int model_dx(input int y, input int g);
        int yc, sq, p, q;
        yc = (y > 16) ? 16 : ((y < -16) ? -16 : y);
        sq = (yc * yc) / 16;
        p  = g * (16 - sq);
        q  = p / 16;
        if (p < 0 && (p % 16) != 0) q = q - 1;
        if (q > (2 ** (DW - 1)) - 1) q = (2 ** (DW - 1)) - 1;
        if (q < -(2 ** (DW - 1))) q = -(2 ** (DW - 1));
        return q;
    endfunction

    always @(negedge clk) begin
        int yi, gi, e;
        if (rst) begin
            exp_q.delete();
            m_pos   = 0;
            m_clamp = 1'b0;
        end else begin
            chk("clamp_seen", int'(clamp_seen), int'(m_clamp));
            if (!out_valid) chk("last_idle", int'(out_last), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", int'(out), e);
                    chk("out_last", int'(out_last), int'(m_pos == VL - 1));
                end
            end
            yi = int'(in_y);
            gi = int'(in_g);
            if (in_valid && in_ready) exp_q.push_back(model_dx(yi, gi));
            if (clear) m_clamp = 1'b0;
            else if (in_valid && in_ready && (yi > 16 || yi < -16)) m_clamp = 1'b1;
            if (clear) m_pos = 0;
            else if (out_valid && out_ready) m_pos = (m_pos + 1) % VL;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int y, input int g);
        int n;
        in_y = DW'(y);
        in_g = DW'(g);
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 300) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_y = '0; in_g = '0; out_ready = 1'b1; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_clamp", int'(clamp_seen), 0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", int'(in_ready), 1);

        // latency of a single element
        send(8, 16);
        in_valid = 1'b0;
        chk("lat_c1_valid", int'(out_valid), 0);
        tick();
        chk("lat_c2_valid", int'(out_valid), 0);
        tick();
        chk("lat_c3_valid", int'(out_valid), 1);
        chk("lat_c3_data", int'(out), 12);
        drain();

        // sign and truncation, back to back
        send(-8, -16);
        send(5, 7);
        send(0, -32);
        in_valid = 1'b0;
        drain();

        // clamp flag
        send(40, 50);
        in_valid = 1'b0;
        chk("clamp_set", int'(clamp_seen), 1);
        drain();
        pulse_clear();
        chk("clamp_clear", int'(clamp_seen), 0);
        send(16, 1);
        in_valid = 1'b0;
        tick();
        chk("clamp_y16", int'(clamp_seen), 0);
        drain();

        // backpressure
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 5; i++) send(0, i);
                in_valid = 1'b0;
                bp_done = 1'b1;
            end
        join_none
        repeat (6) tick();
        chk("bp_accepted", exp_q.size(), 3);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_hold_a", int'(out), 1);
        tick();
        chk("bp_hold_b", int'(out), 1);
        chk("bp_valid_b", int'(out_valid), 1);
        out_ready = 1'b1;
        for (int n = 0; n < 100 && !bp_done; n++) tick();
        chk("bp_done", int'(bp_done), 1);
        drain();

        // vector framing with random downstream stalls
        pulse_clear();
        rand_rdy = 1'b1;
        for (int i = 0; i < 9; i++) send($urandom_range(0, 40) - 20, $urandom_range(0, 255) - 128);
        in_valid = 1'b0;
        drain();
        rand_rdy = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(0, 10 + i);
        in_valid = 1'b0;
        drain();

        // random stream across the full input range
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        drain();
        rand_rdy = 1'b0;
        tick();
        out_ready = 1'b1;
        pulse_clear();

        // async reset with elements in flight
        send(3, 4);
        send(-3, 9);
        in_valid = 1'b0;
        tick();
        chk("pre_rst_valid", int'(out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_out", int'(out), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send(8, 16);
        in_valid = 1'b0;
        tick();
        chk("post_rst_c2_valid", int'(out_valid), 0);
        tick();
        chk("post_rst_c3_valid", int'(out_valid), 1);
        chk("post_rst_data", int'(out), 12);
        chk("post_rst_last", int'(out_last), 0);
        for (int i = 0; i < 3; i++) send(0, 1);
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
